// File: rtl/rtc_display_mux_pkg.sv
// Shared constants for the RTC display mux: the display mode encoding and the
// display field indices.
package rtc_disp_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_CR_RUN  = 2'd1,
    MODE_CR_PROG = 2'd2,
    MODE_WRITE   = 2'd3
  } disp_mode_e;

  localparam int F_SEG    = 0;
  localparam int F_MIN    = 1;
  localparam int F_HORA   = 2;
  localparam int F_FECHA  = 3;
  localparam int F_MES    = 4;
  localparam int F_ANO    = 5;
  localparam int F_DIASEM = 6;
  localparam int F_NUMSEM = 7;
  localparam int F_SEG_T  = 8;
  localparam int F_MIN_T  = 9;
  localparam int F_HORA_T = 10;

endpackage

// File: rtl/rtc_display_mux_if.sv
// Bundle of the mode, display-field and keyboard signals exchanged with the
// display mux; the slave modport is the mux side.
interface rtc_display_mux_if #(
  parameter int DATA_W = 8,
  parameter int FIELDS = 11
);
  localparam int CUR_W = $clog2(FIELDS);

  logic                     mode_write;
  logic                     mode_cr_prog;
  logic                     mode_cr_run;
  logic [FIELDS*DATA_W-1:0] src_rtc;
  logic [FIELDS*DATA_W-1:0] src_edit;
  logic [CUR_W-1:0]         cursor;
  logic [FIELDS*DATA_W-1:0] disp_data;
  logic [FIELDS-1:0]        disp_blank;
  logic [1:0]               disp_mode;
  logic                     mode_change;
  logic [DATA_W-1:0]        kb_code;
  logic                     kb_valid;
  logic                     kb_rd;
  logic                     kb_clr;
  logic [DATA_W-1:0]        kb_data;
  logic                     kb_pending;
  logic                     kb_overflow;

  modport master (
    output mode_write, mode_cr_prog, mode_cr_run, src_rtc, src_edit, cursor,
           kb_code, kb_valid, kb_rd, kb_clr,
    input  disp_data, disp_blank, disp_mode, mode_change,
           kb_data, kb_pending, kb_overflow
  );

  modport slave (
    input  mode_write, mode_cr_prog, mode_cr_run, src_rtc, src_edit, cursor,
           kb_code, kb_valid, kb_rd, kb_clr,
    output disp_data, disp_blank, disp_mode, mode_change,
           kb_data, kb_pending, kb_overflow
  );

endinterface

// File: rtl/rtc_display_mux_kb_fifo.sv
// First-word-fall-through keyboard code FIFO with a sticky overflow flag.
// When empty the output holds the last popped code (0 after reset or clear).
module kb_fifo #(
  parameter int DATA_W   = 8,
  parameter int KB_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_code,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_pending,
  output logic              o_overflow
);
  localparam int AW = $clog2(KB_DEPTH);

  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic [DATA_W-1:0] r_mem [KB_DEPTH];
  logic [DATA_W-1:0] r_last;
  logic              r_ovf;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_rd && !w_empty;
  // A read in the same cycle frees the slot, so a push into a full FIFO is legal.
  assign w_push  = i_valid && (!w_full || i_rd);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_last <= '0;
      r_ovf  <= 1'b0;
    end else if (i_clr) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_last <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_last <= r_mem[r_rd[AW-1:0]];
      end
      if (i_valid && w_full && !i_rd) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr && !i_reset) r_mem[r_wr[AW-1:0]] <= i_code;
  end

  assign o_data     = w_empty ? r_last : r_mem[r_rd[AW-1:0]];
  assign o_pending  = !w_empty;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/rtc_display_mux.sv
// Registered per-field display source select with cursor blink mask, plus the
// keyboard code FIFO feeding the PicoBlaze.
module rtc_display_mux
  import rtc_disp_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIELDS       = 11,
  parameter int TIMER_FIELDS = 3,
  parameter int BLINK_HALF   = 25_000_000,
  parameter int KB_DEPTH     = 4
) (
  input logic           i_clk,
  input logic           i_reset,
  rtc_display_mux_if.slave bus
);
  localparam int DATE_FIELDS = FIELDS - TIMER_FIELDS;
  localparam int CUR_W       = $clog2(FIELDS);
  localparam int CNT_W       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  disp_mode_e               w_mode;
  disp_mode_e               r_mode;
  logic                     w_mode_chg;
  logic                     w_wrap;
  logic                     w_phase_next;
  logic [FIELDS*DATA_W-1:0] w_data;
  logic [FIELDS-1:0]        w_blank;
  logic [FIELDS*DATA_W-1:0] r_data;
  logic [FIELDS-1:0]        r_blank;
  logic                     r_mode_change;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_phase;

  always_comb begin
    w_mode = MODE_IDLE;
    if (bus.mode_write)        w_mode = MODE_WRITE;
    else if (bus.mode_cr_prog) w_mode = MODE_CR_PROG;
    else if (bus.mode_cr_run)  w_mode = MODE_CR_RUN;
  end

  assign w_mode_chg   = (w_mode != r_mode);
  assign w_wrap       = (r_cnt == CNT_LAST);
  assign w_phase_next = w_mode_chg ? 1'b0 : (w_wrap ? ~r_phase : r_phase);

  always_comb begin
    w_data = '0;
    for (int i = 0; i < FIELDS; i++) begin
      if (i < DATE_FIELDS) begin
        w_data[i*DATA_W +: DATA_W] = (w_mode == MODE_WRITE) ? bus.src_edit[i*DATA_W +: DATA_W]
                                                             : bus.src_rtc[i*DATA_W +: DATA_W];
      end else begin
        case (w_mode)
          MODE_CR_PROG: w_data[i*DATA_W +: DATA_W] = bus.src_edit[i*DATA_W +: DATA_W];
          MODE_CR_RUN:  w_data[i*DATA_W +: DATA_W] = bus.src_rtc[i*DATA_W +: DATA_W];
          default:      w_data[i*DATA_W +: DATA_W] = '0;
        endcase
      end
    end
  end

  // Only a cursor inside the group being edited may blank; out-of-range never matches.
  always_comb begin
    w_blank = '0;
    for (int i = 0; i < FIELDS; i++) begin
      if (bus.cursor == CUR_W'(i)) begin
        w_blank[i] = w_phase_next &&
                     (((w_mode == MODE_WRITE) && (i < DATE_FIELDS)) ||
                      ((w_mode == MODE_CR_PROG) && (i >= DATE_FIELDS)));
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode        <= MODE_IDLE;
      r_mode_change <= 1'b0;
      r_data        <= '0;
      r_blank       <= '0;
      r_cnt         <= '0;
      r_phase       <= 1'b0;
    end else begin
      r_mode        <= w_mode;
      r_mode_change <= w_mode_chg;
      r_data        <= w_data;
      r_blank       <= w_blank;
      r_phase       <= w_phase_next;
      if (w_mode_chg || w_wrap) r_cnt <= '0;
      else                      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.disp_data   = r_data;
  assign bus.disp_blank  = r_blank;
  assign bus.disp_mode   = r_mode;
  assign bus.mode_change = r_mode_change;

  kb_fifo #(
    .DATA_W   (DATA_W),
    .KB_DEPTH (KB_DEPTH)
  ) u_kb_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (bus.kb_clr),
    .i_valid    (bus.kb_valid),
    .i_code     (bus.kb_code),
    .i_rd       (bus.kb_rd),
    .o_data     (bus.kb_data),
    .o_pending  (bus.kb_pending),
    .o_overflow (bus.kb_overflow)
  );

endmodule

// File: tb/tb_rtc_display_mux.sv
// Self-checking bench for rtc_display_mux: mode select, blink mask and the
// keyboard FIFO, with a queue scoreboard for keyboard codes.
module tb_rtc_display_mux;
  localparam int DATA_W = 8;
  localparam int FIELDS = 11;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] exp_code;

  rtc_display_mux_if #(.DATA_W(DATA_W), .FIELDS(FIELDS)) bus();

  rtc_display_mux #(
    .DATA_W(DATA_W), .FIELDS(FIELDS), .TIMER_FIELDS(3), .BLINK_HALF(4), .KB_DEPTH(4)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_code(input logic [7:0] code, input bit expect_store);
    bus.kb_code  = code;
    bus.kb_valid = 1'b1;
    if (expect_store) sb_q.push_back(code);
    tick();
    bus.kb_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.disp_data !== '0 || bus.disp_blank !== '0 || bus.disp_mode !== 2'd0 ||
        bus.mode_change !== 1'b0 || bus.kb_pending !== 1'b0 || bus.kb_overflow !== 1'b0 ||
        bus.kb_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: data=%h blank=%h mode=%0d mc=%b pend=%b ovf=%b kb=%h, want all 0",
               bus.disp_data, bus.disp_blank, bus.disp_mode, bus.mode_change,
               bus.kb_pending, bus.kb_overflow, bus.kb_data);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mode_priority();
    bus.src_rtc  = {11{8'h11}};
    bus.src_edit = {11{8'h22}};
    bus.mode_write = 1'b1; bus.mode_cr_prog = 1'b1;
    tick();
    checks++;
    if (bus.disp_data !== {{3{8'h00}}, {8{8'h22}}} || bus.disp_mode !== 2'd3 || bus.mode_change !== 1'b1) begin
      failures++;
      $display("FAIL write_over_prog: data=%h mode=%0d mc=%b, want %h mode=3 mc=1",
               bus.disp_data, bus.disp_mode, bus.mode_change, {{3{8'h00}}, {8{8'h22}}});
    end
    tick();
    checks++;
    if (bus.mode_change !== 1'b0) begin
      failures++;
      $display("FAIL mode_change_pulse: mc=%b, want 0", bus.mode_change);
    end
    bus.mode_write = 1'b0;
    tick();
    checks++;
    if (bus.disp_data !== {{3{8'h22}}, {8{8'h11}}} || bus.disp_mode !== 2'd2 || bus.mode_change !== 1'b1) begin
      failures++;
      $display("FAIL cr_prog_select: data=%h mode=%0d mc=%b, want %h mode=2 mc=1",
               bus.disp_data, bus.disp_mode, bus.mode_change, {{3{8'h22}}, {8{8'h11}}});
    end
    bus.mode_cr_prog = 1'b0; bus.mode_cr_run = 1'b1;
    tick();
    checks++;
    if (bus.disp_data !== {11{8'h11}} || bus.disp_mode !== 2'd1) begin
      failures++;
      $display("FAIL cr_run_select: data=%h mode=%0d, want all 11 mode=1", bus.disp_data, bus.disp_mode);
    end
    bus.mode_cr_run = 1'b0;
    tick();
    checks++;
    if (bus.disp_data !== {{3{8'h00}}, {8{8'h11}}} || bus.disp_mode !== 2'd0 || bus.mode_change !== 1'b1) begin
      failures++;
      $display("FAIL idle_select: data=%h mode=%0d mc=%b, want %h mode=0 mc=1",
               bus.disp_data, bus.disp_mode, bus.mode_change, {{3{8'h00}}, {8{8'h11}}});
    end
    tick();
  endtask

  task automatic test_blink();
    logic [10:0] exp;
    bus.cursor = 4'd2;
    bus.mode_write = 1'b1;
    tick();
    for (int n = 0; n < 16; n++) begin
      exp = (((n / 4) % 2) == 1) ? 11'h004 : 11'h000;
      checks++;
      if (bus.disp_blank !== exp) begin
        failures++;
        $display("FAIL blink_write_c2 n=%0d: blank=%h, want %h", n, bus.disp_blank, exp);
      end
      tick();
    end
    bus.cursor = 4'd9;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (bus.disp_blank !== 11'h000) begin
        failures++;
        $display("FAIL blink_write_c9 n=%0d: blank=%h, want 000", n, bus.disp_blank);
      end
    end
    bus.cursor = 4'd15;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (bus.disp_blank !== 11'h000) begin
        failures++;
        $display("FAIL blink_c15 n=%0d: blank=%h, want 000", n, bus.disp_blank);
      end
    end
    bus.mode_write = 1'b0; bus.mode_cr_prog = 1'b1; bus.cursor = 4'd9;
    tick();
    for (int n = 0; n < 8; n++) begin
      exp = (n >= 4) ? 11'h200 : 11'h000;
      checks++;
      if (bus.disp_blank !== exp) begin
        failures++;
        $display("FAIL blink_prog_c9 n=%0d: blank=%h, want %h", n, bus.disp_blank, exp);
      end
      tick();
    end
    bus.mode_cr_prog = 1'b0; bus.cursor = 4'd0;
    tick();
  endtask

  task automatic drain(input string name);
    while (sb_q.size() > 0) begin
      exp_code = sb_q.pop_front();
      checks++;
      if (bus.kb_pending !== 1'b1 || bus.kb_data !== exp_code) begin
        failures++;
        $display("FAIL %s: pend=%b data=%h, want pend=1 data=%h", name, bus.kb_pending, bus.kb_data, exp_code);
      end
      bus.kb_rd = 1'b1;
      tick();
      bus.kb_rd = 1'b0;
    end
    checks++;
    if (bus.kb_pending !== 1'b0) begin
      failures++;
      $display("FAIL %s_empty: pend=%b, want 0", name, bus.kb_pending);
    end
  endtask

  task automatic test_fifo_fill();
    for (int i = 0; i < 5; i++) push_code(8'(8'h41 + i), i < 4);
    checks++;
    if (bus.kb_overflow !== 1'b1 || bus.kb_pending !== 1'b1) begin
      failures++;
      $display("FAIL fill_overflow: ovf=%b pend=%b, want 1 1", bus.kb_overflow, bus.kb_pending);
    end
    drain("fill_read");
    checks++;
    if (bus.kb_data !== 8'h44 || bus.kb_overflow !== 1'b1) begin
      failures++;
      $display("FAIL hold_last: data=%h ovf=%b, want 44 1", bus.kb_data, bus.kb_overflow);
    end
    bus.kb_rd = 1'b1;
    tick();
    bus.kb_rd = 1'b0;
    checks++;
    if (bus.kb_pending !== 1'b0 || bus.kb_data !== 8'h44) begin
      failures++;
      $display("FAIL rd_empty: pend=%b data=%h, want 0 44", bus.kb_pending, bus.kb_data);
    end
    bus.kb_clr = 1'b1;
    tick();
    bus.kb_clr = 1'b0;
    checks++;
    if (bus.kb_overflow !== 1'b0 || bus.kb_data !== 8'h00) begin
      failures++;
      $display("FAIL clr_state: ovf=%b data=%h, want 0 00", bus.kb_overflow, bus.kb_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) push_code(8'(8'h61 + i), 1'b1);
    void'(sb_q.pop_front());
    sb_q.push_back(8'h50);
    bus.kb_code = 8'h50; bus.kb_valid = 1'b1; bus.kb_rd = 1'b1;
    tick();
    bus.kb_valid = 1'b0; bus.kb_rd = 1'b0;
    checks++;
    if (bus.kb_overflow !== 1'b0) begin
      failures++;
      $display("FAIL simul_no_ovf: ovf=%b, want 0", bus.kb_overflow);
    end
    drain("simul_read");
  endtask

  task automatic test_kb_clr();
    for (int i = 0; i < 5; i++) push_code(8'(8'h30 + i), 1'b0);
    bus.kb_code = 8'h77; bus.kb_valid = 1'b1; bus.kb_clr = 1'b1;
    tick();
    bus.kb_valid = 1'b0; bus.kb_clr = 1'b0;
    checks++;
    if (bus.kb_pending !== 1'b0 || bus.kb_overflow !== 1'b0 || bus.kb_data !== 8'h00) begin
      failures++;
      $display("FAIL clr_with_push: pend=%b ovf=%b data=%h, want 0 0 00",
               bus.kb_pending, bus.kb_overflow, bus.kb_data);
    end
  endtask

  task automatic test_reset_midstream();
    bus.mode_write = 1'b1;
    for (int i = 0; i < 3; i++) push_code(8'(8'h10 + i), 1'b1);
    checks++;
    if (bus.kb_pending !== 1'b1 || bus.disp_mode !== 2'd3) begin
      failures++;
      $display("FAIL pre_reset: pend=%b mode=%0d, want 1 3", bus.kb_pending, bus.disp_mode);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.kb_pending !== 1'b0 || bus.disp_data !== '0 || bus.disp_mode !== 2'd0 || bus.kb_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_midstream: pend=%b data=%h mode=%0d kb=%h, want all 0",
               bus.kb_pending, bus.disp_data, bus.disp_mode, bus.kb_data);
    end
    sb_q.delete();
    bus.mode_write = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0;
    bus.mode_write = 1'b0; bus.mode_cr_prog = 1'b0; bus.mode_cr_run = 1'b0;
    bus.src_rtc = '0; bus.src_edit = '0; bus.cursor = '0;
    bus.kb_code = '0; bus.kb_valid = 1'b0; bus.kb_rd = 1'b0; bus.kb_clr = 1'b0;
    test_reset();
    test_mode_priority();
    test_blink();
    test_fifo_fill();
    test_back_to_back();
    test_kb_clr();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_display_mux.md
# rtc_display_mux

Registered display-data selector and keyboard-code buffer between the RTC state machines, the PicoBlaze and the VGA interface. Each cycle it picks, per display field, either live RTC data, edit-machine data or zero according to the active mode. It adds a blink mask for the field under the cursor and a small first-word-fall-through FIFO for keyboard codes. The FIFO replaces the single-entry ASCII latch, so no keystroke is lost while the PicoBlaze is busy.

## Interface
- DATA_W, 8, width of one display field / keyboard code
- FIELDS, 11, total display fields; field 0 = seconds … field FIELDS-1 = last timer field
- TIMER_FIELDS, 3, number of timer fields, occupying indices FIELDS-TIMER_FIELDS..FIELDS-1
- BLINK_HALF, 25_000_000, clk cycles per blink half-period
- KB_DEPTH, 4, keyboard FIFO depth (power of two, ≥2)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mode_write  in  1  clock/date edit mode
- mode_cr_prog  in  1  timer programming mode
- mode_cr_run  in  1  timer running mode
- src_rtc  in  FIELDS*DATA_W  live RTC fields, field i at bits [i*DATA_W +: DATA_W]
- src_edit  in  FIELDS*DATA_W  edit-machine fields, same packing
- cursor  in  clog2(FIELDS)  index of the field being edited
- disp_data  out  FIELDS*DATA_W  registered fields to the VGA interface
- disp_blank  out  FIELDS  1 = field i blanked this blink phase
- disp_mode  out  2  0 idle, 1 cr_run, 2 cr_prog, 3 write
- mode_change  out  1  one-cycle pulse when disp_mode changes
- kb_code  in  DATA_W  ASCII from the keyboard block
- kb_valid  in  1  one-cycle strobe, kb_code valid
- kb_rd  in  1  PicoBlaze acknowledge; pops the head
- kb_clr  in  1  synchronous clear of the FIFO and overflow
- kb_data  out  DATA_W  FIFO head (FWFT)
- kb_pending  out  1  FIFO non-empty; drives PicoBlaze interrupt
- kb_overflow  out  1  sticky; a code was dropped

## Operation
- Mode priority: write > cr_prog > cr_run > idle. Several mode inputs may be high at once; the highest-priority one wins.
- Field source, date fields (index < FIELDS-TIMER_FIELDS):
  - write: src_edit.
  - All other modes: src_rtc.
- Field source, timer fields:
  - write: 0.
  - cr_prog: src_edit.
  - cr_run: src_rtc.
  - idle: 0.
- Blink: a counter of width clog2(BLINK_HALF) counts 0..BLINK_HALF-1 and wraps. Each wrap toggles the phase.
  - Phase restarts at "visible" with counter 0 on every mode_change.
  - disp_blank[cursor] = phase, only in write or cr_prog. All other bits are 0.
  - cursor ≥ FIELDS produces no blanking.
  - In write mode, only a cursor < FIELDS-TIMER_FIELDS may blank; in cr_prog, only a timer index may blank. An out-of-group cursor produces no blanking.
- Keyboard FIFO: KB_DEPTH entries with read/write pointers of clog2(KB_DEPTH)+1 bits; full and empty are decoded from the MSB.
  - kb_valid with not full: push.
  - kb_valid with full and no kb_rd: code dropped, kb_overflow set.
  - kb_valid and kb_rd in the same cycle while full: pop and push both occur, no overflow.
  - kb_rd while empty: ignored.
  - kb_clr: empties the FIFO and clears kb_overflow. It has priority over a simultaneous push or pop.

## Timing
- Reset values: disp_data all 0, disp_blank 0, disp_mode 0, mode_change 0, kb_pending 0, kb_overflow 0, kb_data 0, blink counter and phase 0, FIFO pointers 0.
- disp_data, disp_blank and disp_mode are registered, with 1-cycle latency from mode, src or cursor inputs.
- mode_change is high in the cycle disp_mode takes its new value.
- Blink toggles on the cycle after the counter reaches BLINK_HALF-1, so a half-period is exactly BLINK_HALF cycles.
- Push at edge N: kb_pending high and kb_data = code after edge N (FWFT). The same-cycle rule applies to pop.
- kb_data is combinational from the head of storage. It holds the last popped value when empty, or 0 after reset/clear.
- Reset asserted mid-operation discards FIFO contents and blink phase immediately; outputs return to reset values asynchronously.

## Structure
- Shared package rtc_disp_pkg holds:
  - the mode encoding constants (MODE_IDLE=0, MODE_CR_RUN=1, MODE_CR_PROG=2, MODE_WRITE=3);
  - the field index constants (F_SEG, F_MIN, F_HORA, F_FECHA, F_MES, F_ANO, F_DIASEM, F_NUMSEM, F_SEG_T, F_MIN_T, F_HORA_T).
- One sub-module, kb_fifo (parametrised DATA_W, KB_DEPTH), holding the FIFO, pointers and the overflow flag.
- The select, blink and mode logic stays in the top of the block.

## Test plan
- Reset mid-stream: push 3 codes, assert reset → kb_pending=0, disp_data=0, disp_mode=0 immediately.
- Mode priority: src_rtc fields = 0x11, src_edit fields = 0x22.
  - mode_write=1 and mode_cr_prog=1 → next cycle, date fields 0x22, timer fields 0x00, disp_mode=3, mode_change pulses once.
  - Then write=0 → timer fields 0x22, date fields 0x11, disp_mode=2.
- Blink: BLINK_HALF=4, write mode, cursor=2 → disp_blank = 0x004 every other 4-cycle window.
  - cursor=9 in write mode → disp_blank=0.
  - cursor=15 → disp_blank=0.
- FIFO fill/overflow: KB_DEPTH=4, push 0x41..0x45 with no reads → 0x45 dropped, kb_overflow=1.
  - Four kb_rd pulses return 0x41, 0x42, 0x43, 0x44; kb_pending falls after the 4th.
- Simultaneous: FIFO full, kb_valid (0x50) with kb_rd → head popped, 0x50 stored, kb_overflow stays 0.
- kb_clr during a kb_valid → FIFO empty, kb_pending=0, kb_overflow=0.
